// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle execute-stage ALU.
//
// Decodes the main-control aluop/funct/immedateop fields into a 3-bit
// operation code (gout, combinational) and, on an accepted start, executes
// that operation on the latched WIDTH-bit operands.
//   * Logical / arithmetic ops: one execute cycle, then a one-cycle done pulse.
//   * Multiply: unsigned iterative shift-add, one multiplier bit per cycle,
//     producing a 2*WIDTH-bit product in result_hi:result.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset, clears all state
//   start       request, accepted when idle or in the done cycle
//   aluop       main-control ALU op class
//   funct       instruction funct[3:0]
//   immedateop  immediate-op select (00 = none)
//   a, b        operands, latched on accept
//   gout        combinational decode of the current fields
//   busy        multiply iterations in progress
//   done        one-cycle pulse, outputs valid
//   result      result (low product word for mul)
//   result_hi   high product word (mul only, else 0)
//   zero        result == 0
//   ovf         signed overflow (add/sub only, else 0)
//
// Op codes: 000 and, 001 or, 010 add, 011 mul, 100 nor, 101 add,
//           110 sub, 111 slt (signed).

module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [3:0]       funct,
  input  logic [1:0]       immedateop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       gout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_AD2 = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // IDLE  : waiting for start
  // EXEC  : operands latched; compute (or launch the multiplier) next edge
  // MUL   : shift-add iterations, busy=1
  // DONE  : done pulse; a start here is accepted like in IDLE
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2:0]         op_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   result_reg;
  logic [WIDTH-1:0]   result_hi_reg;
  logic               zero_reg;
  logic               ovf_reg;

  // ---------------------------------------------------------------
  // Decode: first match wins. casez is evaluated in order, so the
  // overlapping funct patterns resolve by their listed priority
  // (e.g. 0111 is nor even though it also matches x1x1).
  // ---------------------------------------------------------------
  always_comb begin
    gout = OP_ADD;
    if (immedateop == 2'b01) begin
      gout = OP_ADD;
    end else if (immedateop == 2'b10) begin
      gout = OP_AND;
    end else if (immedateop == 2'b11) begin
      gout = OP_ADD;
    end else if (aluop == 2'b00) begin
      gout = OP_ADD;
    end else if (aluop == 2'b01) begin
      gout = OP_SUB;
    end else begin
      casez (funct)
        4'b1111: gout = OP_MUL;
        4'b?1?0: gout = OP_AND;
        4'b0111: gout = OP_NOR;
        4'b?1?1: gout = OP_OR;
        4'b0?1?: gout = OP_SUB;
        4'b1?1?: gout = OP_SLT;
        4'b0000: gout = OP_ADD;
        default: gout = aluop[0] ? OP_SUB : OP_ADD;
      endcase
    end
  end

  // Start is honoured only when no operation is outstanding. The EXEC
  // cycle is not busy but still refuses a new start, which is what
  // limits a held start to one non-mul op every two cycles.
  logic accept;
  assign accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

  // ---------------------------------------------------------------
  // Single-cycle datapath on the latched operands
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] and_v, or_v, nor_v;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign and_v[gi] = a_reg[gi] & b_reg[gi];
      assign or_v[gi]  = a_reg[gi] | b_reg[gi];
      assign nor_v[gi] = ~(a_reg[gi] | b_reg[gi]);
    end
  endgenerate

  logic [WIDTH-1:0] sum_v, diff_v;
  logic             add_ovf, sub_ovf, slt_v;

  assign sum_v  = a_reg + b_reg;
  assign diff_v = a_reg - b_reg;
  // Same-sign inputs producing an opposite-sign sum overflow; for
  // subtraction the operands must differ in sign instead.
  assign add_ovf = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_v[WIDTH-1]  != a_reg[WIDTH-1]);
  assign sub_ovf = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff_v[WIDTH-1] != a_reg[WIDTH-1]);
  assign slt_v   = $signed(a_reg) < $signed(b_reg);

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_reg)
      OP_AND: alu_res = and_v;
      OP_OR:  alu_res = or_v;
      OP_NOR: alu_res = nor_v;
      OP_ADD, OP_AD2: begin
        alu_res = sum_v;
        alu_ovf = add_ovf;
      end
      OP_SUB: begin
        alu_res = diff_v;
        alu_ovf = sub_ovf;
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_v};
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------
  // Shift-add multiplier step. prod_reg holds the accumulator in the
  // high half and the not-yet-consumed multiplier bits in the low half;
  // each step conditionally adds the multiplicand to the accumulator and
  // shifts the whole register right, pulling the carry in at the top.
  // ---------------------------------------------------------------
  logic [WIDTH:0]     hi_sum;
  logic [2*WIDTH-1:0] prod_step;

  assign hi_sum    = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} +
                     (prod_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
  assign prod_step = {hi_sum, prod_reg[WIDTH-1:1]};

  // ---------------------------------------------------------------
  // Control and state
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= '0;
      cnt_reg       <= '0;
      prod_reg      <= '0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            op_reg    <= gout;
            state_reg <= S_EXEC;
          end else begin
            state_reg <= S_IDLE;
          end
        end

        S_EXEC: begin
          if (op_reg == OP_MUL) begin
            cnt_reg   <= '0;
            prod_reg  <= {{WIDTH{1'b0}}, b_reg};
            state_reg <= S_MUL;
          end else begin
            result_reg    <= alu_res;
            result_hi_reg <= '0;
            zero_reg      <= (alu_res == '0);
            ovf_reg       <= alu_ovf;
            state_reg     <= S_DONE;
          end
        end

        S_MUL: begin
          prod_reg <= prod_step;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH-1)) begin
            result_reg    <= prod_step[WIDTH-1:0];
            result_hi_reg <= prod_step[2*WIDTH-1:WIDTH];
            zero_reg      <= (prod_step[WIDTH-1:0] == '0);
            ovf_reg       <= 1'b0;
            state_reg     <= S_DONE;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_reg == S_MUL);
  assign done      = (state_reg == S_DONE);
  assign result    = result_reg;
  assign result_hi = result_hi_reg;
  assign zero      = zero_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc: a 32-bit instance for decode/arith/random checks and
// an 8-bit instance for the multiply handshake and reset-abort scenarios.
module tb_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst32, start32;
  logic [1:0]  aluop32, imm32;
  logic [3:0]  funct32;
  logic [31:0] a32, b32, res32, hi32;
  logic [2:0]  gout32;
  logic        busy32, done32, zero32, ovf32;

  // 8-bit instance
  logic        rst8, start8;
  logic [1:0]  aluop8, imm8;
  logic [3:0]  funct8;
  logic [7:0]  a8, b8, res8, hi8;
  logic [2:0]  gout8;
  logic        busy8, done8, zero8, ovf8;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst32), .start(start32), .aluop(aluop32), .funct(funct32),
    .immedateop(imm32), .a(a32), .b(b32), .gout(gout32), .busy(busy32),
    .done(done32), .result(res32), .result_hi(hi32), .zero(zero32), .ovf(ovf32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .start(start8), .aluop(aluop8), .funct(funct8),
    .immedateop(imm8), .a(a8), .b(b8), .gout(gout8), .busy(busy8),
    .done(done8), .result(res8), .result_hi(hi8), .zero(zero8), .ovf(ovf8)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  function automatic logic [2:0] exp_gout(input logic [1:0] al, input logic [3:0] fn,
                                          input logic [1:0] im);
    if (im == 2'b01) return 3'b010;
    if (im == 2'b10) return 3'b000;
    if (im == 2'b11) return 3'b010;
    if (al == 2'b00) return 3'b010;
    if (al == 2'b01) return 3'b110;
    if (fn ==? 4'b1111) return 3'b011;
    if (fn ==? 4'bx1x0) return 3'b000;
    if (fn ==? 4'b0111) return 3'b100;
    if (fn ==? 4'bx1x1) return 3'b001;
    if (fn ==? 4'b0x1x) return 3'b110;
    if (fn ==? 4'b1x1x) return 3'b111;
    if (fn ==? 4'b0000) return 3'b010;
    return al[0] ? 3'b110 : 3'b010;
  endfunction

  task automatic model32(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic [31:0] h, output logic v);
    longint sx, sy, s;
    int t;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 32'd0; h = 32'd0; v = 1'b0;
    case (op)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b100: r = ~(x | y);
      3'b010, 3'b101, 3'b110: begin
        s = (op == 3'b110) ? (sx - sy) : (sx + sy);
        r = s[31:0];
        t = int'(s[31:0]);
        v = (longint'(t) != s);   // true sum does not fit a signed 32-bit word
      end
      3'b111: r = (sx < sy) ? 32'd1 : 32'd0;
      default: begin
        p = 64'(x) * 64'(y);
        r = p[31:0];
        h = p[63:32];
      end
    endcase
  endtask

  // ---------------- drivers ----------------
  task automatic run32(input logic [1:0] al, input logic [3:0] fn, input logic [1:0] im,
                       input logic [31:0] av, input logic [31:0] bv,
                       output int lat, output int busyc);
    @(negedge clk);
    aluop32 = al; funct32 = fn; imm32 = im; a32 = av; b32 = bv; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    lat = 0; busyc = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy32) busyc++;
      if (done32) break;
    end
  endtask

  task automatic run8(input logic [1:0] al, input logic [3:0] fn, input logic [1:0] im,
                      input logic [7:0] av, input logic [7:0] bv, output int lat);
    @(negedge clk);
    aluop8 = al; funct8 = fn; imm8 = im; a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done8) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst32 = 1'b1; rst8 = 1'b1;
    start32 = 1'b1; start8 = 1'b1;   // reset must win over start
    aluop32 = 2'b00; funct32 = 4'd0; imm32 = 2'b00; a32 = 32'd1; b32 = 32'd1;
    aluop8 = 2'b00; funct8 = 4'd0; imm8 = 2'b00; a8 = 8'd1; b8 = 8'd1;
    repeat (3) @(negedge clk);
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy32 got=%b exp=0", busy32); end
    checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_done32 got=%b exp=0", done32); end
    checks++; if (res32 !== 32'd0) begin errors++; $display("FAIL reset_result32 got=%h exp=0", res32); end
    checks++; if (hi32 !== 32'd0) begin errors++; $display("FAIL reset_hi32 got=%h exp=0", hi32); end
    checks++; if (zero32 !== 1'b0) begin errors++; $display("FAIL reset_zero32 got=%b exp=0", zero32); end
    checks++; if (ovf32 !== 1'b0) begin errors++; $display("FAIL reset_ovf32 got=%b exp=0", ovf32); end
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'd0)
      begin errors++; $display("FAIL reset_dut8 got busy=%b done=%b res=%h exp 0/0/00", busy8, done8, res8); end
    start32 = 1'b0; start8 = 1'b0;
    rst32 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_no_done got=%b exp=0", done32); end
    $display("test_reset: done");
  endtask

  task automatic test_add();
    int lat, bc;
    run32(2'b10, 4'b0000, 2'b00, 32'd5, 32'd7, lat, bc);
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (bc !== 0) begin errors++; $display("FAIL add_busy got=%0d exp=0", bc); end
    checks++; if (res32 !== 32'd12) begin errors++; $display("FAIL add_result got=%0d exp=12", res32); end
    checks++; if (zero32 !== 1'b0 || ovf32 !== 1'b0 || hi32 !== 32'd0)
      begin errors++; $display("FAIL add_flags got zero=%b ovf=%b hi=%h exp 0/0/0", zero32, ovf32, hi32); end
    checks++; if (gout32 !== 3'b010) begin errors++; $display("FAIL add_gout got=%b exp=010", gout32); end
    $display("add 5+7: result=%0d lat=%0d", res32, lat);
  endtask

  task automatic test_slt_ovf();
    int lat, bc;
    run32(2'b10, 4'b1010, 2'b00, 32'hFFFF_FFFF, 32'd1, lat, bc);
    checks++; if (res32 !== 32'd1) begin errors++; $display("FAIL slt_result got=%h exp=1", res32); end
    $display("slt -1<1: result=%0d", res32);
    run32(2'b01, 4'b0000, 2'b00, 32'h8000_0000, 32'd1, lat, bc);
    checks++; if (res32 !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_result got=%h exp=7fffffff", res32); end
    checks++; if (ovf32 !== 1'b1) begin errors++; $display("FAIL sub_ovf got=%b exp=1", ovf32); end
    $display("sub 0x80000000-1: result=%h ovf=%b", res32, ovf32);
  endtask

  task automatic test_decode();
    logic [2:0] e;
    int bad;
    bad = 0;
    for (int im = 0; im < 4; im++)
      for (int al = 0; al < 4; al++)
        for (int fn = 0; fn < 16; fn++) begin
          @(negedge clk);
          aluop32 = 2'(al); funct32 = 4'(fn); imm32 = 2'(im);
          #1;
          e = exp_gout(2'(al), 4'(fn), 2'(im));
          checks++;
          if (gout32 !== e) begin
            errors++; bad++;
            $display("FAIL decode im=%0d al=%0d fn=%b got=%b exp=%b", im, al, fn, gout32, e);
          end
        end
    @(negedge clk); imm32 = 2'b00; aluop32 = 2'b11; funct32 = 4'b0001; #1;
    checks++; if (gout32 !== 3'b110) begin errors++; $display("FAIL decode_spot_0001 got=%b exp=110", gout32); end
    funct32 = 4'b0111; #1;
    checks++; if (gout32 !== 3'b100) begin errors++; $display("FAIL decode_spot_0111 got=%b exp=100", gout32); end
    funct32 = 4'b1111; #1;
    checks++; if (gout32 !== 3'b011) begin errors++; $display("FAIL decode_spot_1111 got=%b exp=011", gout32); end
    $display("decode sweep: 256 combos, %0d bad", bad);
  endtask

  task automatic test_random();
    logic [1:0] al, im;
    logic [3:0] fn;
    logic [31:0] x, y, er, eh;
    logic ev;
    logic [2:0] op;
    int lat, bc, elat;
    for (int i = 0; i < 30; i++) begin
      al = 2'($urandom_range(0, 3));
      fn = 4'($urandom_range(0, 15));
      im = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (i % 5 == 0) begin al = 2'b10; fn = 4'b1111; im = 2'b00; end
      case ($urandom_range(0, 5))
        0: x = 32'h7FFF_FFFF;
        1: x = 32'h8000_0000;
        default: x = $urandom;
      endcase
      y = (i % 7 == 3) ? x : $urandom;
      op = exp_gout(al, fn, im);
      model32(op, x, y, er, eh, ev);
      elat = (op == 3'b011) ? 34 : 2;
      run32(al, fn, im, x, y, lat, bc);
      checks++;
      if (lat !== elat || res32 !== er || hi32 !== eh || ovf32 !== ev || zero32 !== (er == 32'd0)) begin
        errors++;
        $display("FAIL rand%0d op=%b a=%h b=%h got lat=%0d r=%h h=%h v=%b z=%b exp lat=%0d r=%h h=%h v=%b z=%b",
                 i, op, x, y, lat, res32, hi32, ovf32, zero32, elat, er, eh, ev, (er == 32'd0));
      end else begin
        $display("rand%0d op=%b a=%h b=%h -> %h_%h ovf=%b", i, op, x, y, hi32, res32, ovf32);
      end
    end
  endtask

  task automatic test_mul8();
    int lat, bc, dones, first_done, n;
    logic hold_bad;
    run8(2'b00, 4'b0000, 2'b00, 8'd3, 8'd4, lat);
    checks++; if (res8 !== 8'd7) begin errors++; $display("FAIL mul8_pre_add got=%h exp=07", res8); end
    @(negedge clk);
    aluop8 = 2'b10; funct8 = 4'b1111; imm8 = 2'b00; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    #1;
    checks++; if (gout8 !== 3'b011) begin errors++; $display("FAIL mul8_gout got=%b exp=011", gout8); end
    @(posedge clk);
    #1 start8 = 1'b0;
    bc = 0; dones = 0; first_done = 0; hold_bad = 1'b0;
    for (n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (busy8) bc++;
      if (busy8 && res8 !== 8'd7) hold_bad = 1'b1;
      if (done8) begin
        dones++;
        if (first_done == 0) first_done = n;
      end
      if (n == 4) begin start8 = 1'b1; aluop8 = 2'b00; a8 = 8'h11; b8 = 8'h22; end
      if (n == 5) start8 = 1'b0;
    end
    checks++; if (bc !== 8) begin errors++; $display("FAIL mul8_busy_cycles got=%0d exp=8", bc); end
    checks++; if (first_done !== 10) begin errors++; $display("FAIL mul8_done_cycle got=%0d exp=10", first_done); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL mul8_done_count got=%0d exp=1", dones); end
    checks++; if (hold_bad !== 1'b0) begin errors++; $display("FAIL mul8_hold result changed while busy"); end
    checks++; if (res8 !== 8'h01 || hi8 !== 8'hFE) begin errors++; $display("FAIL mul8_product got=%h_%h exp=fe_01", hi8, res8); end
    checks++; if (zero8 !== 1'b0 || ovf8 !== 1'b0) begin errors++; $display("FAIL mul8_flags got z=%b v=%b exp 0/0", zero8, ovf8); end
    $display("mul8 ff*ff: %h_%h busy=%0d done_at=%0d dones=%0d", hi8, res8, bc, first_done, dones);
  endtask

  task automatic test_reset_mul();
    int lat, bc, dones;
    @(negedge clk);
    aluop8 = 2'b10; funct8 = 4'b1111; imm8 = 2'b00; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    bc = 0;
    for (int n = 0; n < 20 && bc < 4; n++) begin
      @(negedge clk);
      if (busy8) bc++;
    end
    checks++; if (bc !== 4) begin errors++; $display("FAIL rstmul_reach_busy got=%0d exp=4", bc); end
    rst8 = 1'b1;
    @(negedge clk);
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL rstmul_state got busy=%b done=%b exp 0/0", busy8, done8); end
    checks++; if (res8 !== 8'd0 || hi8 !== 8'd0 || zero8 !== 1'b0 || ovf8 !== 1'b0)
      begin errors++; $display("FAIL rstmul_outputs got r=%h h=%h z=%b v=%b exp all 0", res8, hi8, zero8, ovf8); end
    rst8 = 1'b0;
    dones = 0;
    repeat (15) begin @(negedge clk); if (done8 || busy8) dones++; end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rstmul_no_done got=%0d exp=0", dones); end
    run8(2'b00, 4'b0000, 2'b10, 8'hF0, 8'h3C, lat);
    checks++; if (res8 !== 8'h30 || lat !== 2) begin errors++; $display("FAIL rstmul_and got=%h lat=%0d exp=30 lat=2", res8, lat); end
    $display("reset during mul: aborted, then and -> %h", res8);
  endtask

  task automatic test_back_to_back();
    int pulses, pattern_bad, res_bad;
    @(negedge clk);
    aluop32 = 2'b10; funct32 = 4'b0101; imm32 = 2'b00; a32 = 32'd1; b32 = 32'd2; start32 = 1'b1;
    pulses = 0; pattern_bad = 0; res_bad = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done32 !== ((n % 2) == 0)) pattern_bad++;
      if (done32) begin
        pulses++;
        if (res32 !== 32'd3 || zero32 !== 1'b0) res_bad++;
      end
    end
    start32 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pulses !== 6) begin errors++; $display("FAIL b2b_pulses got=%0d exp=6", pulses); end
    checks++; if (pattern_bad !== 0) begin errors++; $display("FAIL b2b_pattern got=%0d off-cycles exp=0", pattern_bad); end
    checks++; if (res_bad !== 0) begin errors++; $display("FAIL b2b_result got=%0d bad results exp=0", res_bad); end
    $display("back-to-back or: %0d done pulses in 12 cycles", pulses);
  endtask

  initial begin
    rst32 = 1'b1; rst8 = 1'b1; start32 = 1'b0; start8 = 1'b0;
    aluop32 = '0; funct32 = '0; imm32 = '0; a32 = '0; b32 = '0;
    aluop8 = '0; funct8 = '0; imm8 = '0; a8 = '0; b8 = '0;
    test_reset();
    test_add();
    test_slt_ovf();
    test_decode();
    test_random();
    test_mul8();
    test_reset_mul();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
